// File: rtl/alu_arbiter_if.sv
// Requester, result and ALU-pin signals of the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int unsigned N = 32
);

  // Requester side
  logic         REQ0;
  logic [4:0]   OP0;
  logic         CIN0;
  logic [N-1:0] A0;
  logic [N-1:0] B0;
  logic         REQ1;
  logic [4:0]   OP1;
  logic         CIN1;
  logic [N-1:0] A1;
  logic [N-1:0] B1;

  // Completion and result
  logic         DONE0;
  logic         DONE1;
  logic [N-1:0] RES;
  logic         RES_COUT;
  logic         BUSY;

  // ALU pins
  logic [N-1:0] ALU_A;
  logic [N-1:0] ALU_B;
  logic         ALU_C0;
  logic         ALU_M;
  logic [3:0]   ALU_S;
  logic [N-1:0] ALU_F;
  logic         ALU_COUT;

  // Arbiter view
  modport slave (
    input  REQ0, OP0, CIN0, A0, B0,
    input  REQ1, OP1, CIN1, A1, B1,
    input  ALU_F, ALU_COUT,
    output DONE0, DONE1, RES, RES_COUT, BUSY,
    output ALU_A, ALU_B, ALU_C0, ALU_M, ALU_S
  );

  // Requesters plus ALU view
  modport master (
    output REQ0, OP0, CIN0, A0, B0,
    output REQ1, OP1, CIN1, A1, B1,
    output ALU_F, ALU_COUT,
    input  DONE0, DONE1, RES, RES_COUT, BUSY,
    input  ALU_A, ALU_B, ALU_C0, ALU_M, ALU_S
  );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the EX-stage path (port 0) and the
// multicycle unit (port 1): latch the granted operation onto the ALU pins,
// wait LAT settle cycles, capture the result and pulse that port's DONE.
module alu_arbiter #(
  parameter int unsigned N   = 32,
  parameter int unsigned LAT = 1,
  parameter int unsigned CW  = 4
) (
  input logic          CLK,
  input logic          RESET,
  alu_arbiter_if.slave bus
);

  // Parameter sanity: the settle counter must be able to hold LAT-1
  if ((LAT < 1) || (LAT > 15) || ((2 ** CW) <= LAT)) begin : g_param_err
    $error("alu_arbiter: LAT must be 1..15 and 2**CW must exceed LAT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Operation as it is presented on the ALU pins
  typedef struct packed {
    logic         m;
    logic [3:0]   s;
    logic         c0;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } alu_op_t;

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         last_q, last_d;
  logic         gnt_q, gnt_d;
  alu_op_t      op_q, op_d;
  logic [N-1:0] res_q, res_d;
  logic         res_cout_q, res_cout_d;
  logic         done0_q, done0_d;
  logic         done1_q, done1_d;
  logic         busy_q, busy_d;

  alu_op_t      op0_c;
  alu_op_t      op1_c;
  logic         any_req_c;
  logic         sel_c;

  // Candidate operations and round-robin choice (ties go to the port not served last)
  assign op0_c     = {bus.OP0, bus.CIN0, bus.A0, bus.B0};
  assign op1_c     = {bus.OP1, bus.CIN1, bus.A1, bus.B1};
  assign any_req_c = bus.REQ0 | bus.REQ1;
  assign sel_c     = (bus.REQ0 & bus.REQ1) ? ~last_q : bus.REQ1;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req_c) state_d = S_HOLD;
      S_HOLD:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    res_d      = res_q;
    res_cout_d = res_cout_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          gnt_d  = sel_c;
          last_d = sel_c;
          cnt_d  = CW'(LAT - 1);
          op_d   = sel_c ? op1_c : op0_c;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          res_d      = bus.ALU_F;
          res_cout_d = bus.ALU_COUT;
          done0_d    = ~gnt_q;
          done1_d    = gnt_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        op_d = '0;
      end
      default: begin
        op_d = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q      <= '0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      op_q       <= '0;
      res_q      <= '0;
      res_cout_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      res_q      <= res_d;
      res_cout_q <= res_cout_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.DONE0    = done0_q;
  assign bus.DONE1    = done1_q;
  assign bus.RES      = res_q;
  assign bus.RES_COUT = res_cout_q;
  assign bus.BUSY     = busy_q;
  assign bus.ALU_A    = op_q.a;
  assign bus.ALU_B    = op_q.b;
  assign bus.ALU_C0   = op_q.c0;
  assign bus.ALU_M    = op_q.m;
  assign bus.ALU_S    = op_q.s;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (LAT=1 and LAT=3) behind a shared stimulus,
// a behavioural ALU on each pin set, and a scoreboard of expected completions.
module tb_alu_arbiter;

  localparam int unsigned N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         use3;
  logic         req0, req1;
  logic [4:0]   op0, op1;
  logic         cin0, cin1;
  logic [N-1:0] a0, b0, a1, b1;

  alu_arbiter_if #(.N(N)) bus1 ();
  alu_arbiter_if #(.N(N)) bus3 ();

  alu_arbiter #(.N(N), .LAT(1), .CW(4)) u_dut1 (.CLK(clk), .RESET(rst), .bus(bus1));
  alu_arbiter #(.N(N), .LAT(3), .CW(4)) u_dut3 (.CLK(clk), .RESET(rst), .bus(bus3));

  // Behavioural ALU: {COUT, F}
  function automatic logic [N:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic m, input logic [3:0] s, input logic c0);
    logic [N:0] r;
    if (!m) begin
      case (s)
        4'b1001: r = {1'b0, a} + {1'b0, b} + (N+1)'(c0);
        4'b0110: r = {1'b0, a} + {1'b0, ~b} + (N+1)'(c0);
        default: r = {1'b0, a} + (N+1)'(c0);
      endcase
    end else begin
      case (s)
        4'b0110: r = {1'b0, a ^ b};
        4'b1011: r = {1'b0, a & b};
        4'b1110: r = {1'b0, a | b};
        4'b0000: r = {1'b0, ~a};
        default: r = {1'b0, b};
      endcase
    end
    return r;
  endfunction

  assign {bus1.ALU_COUT, bus1.ALU_F} = alu_model(bus1.ALU_A, bus1.ALU_B, bus1.ALU_M, bus1.ALU_S, bus1.ALU_C0);
  assign {bus3.ALU_COUT, bus3.ALU_F} = alu_model(bus3.ALU_A, bus3.ALU_B, bus3.ALU_M, bus3.ALU_S, bus3.ALU_C0);

  // Shared operands; requests go only to the selected instance
  assign bus1.REQ0 = req0 & ~use3;
  assign bus1.REQ1 = req1 & ~use3;
  assign bus3.REQ0 = req0 & use3;
  assign bus3.REQ1 = req1 & use3;
  assign bus1.OP0 = op0;  assign bus1.CIN0 = cin0;  assign bus1.A0 = a0;  assign bus1.B0 = b0;
  assign bus1.OP1 = op1;  assign bus1.CIN1 = cin1;  assign bus1.A1 = a1;  assign bus1.B1 = b1;
  assign bus3.OP0 = op0;  assign bus3.CIN0 = cin0;  assign bus3.A0 = a0;  assign bus3.B0 = b0;
  assign bus3.OP1 = op1;  assign bus3.CIN1 = cin1;  assign bus3.A1 = a1;  assign bus3.B1 = b1;

  // Outputs of the selected instance
  logic         s_done0, s_done1, s_cout, s_busy;
  logic [N-1:0] s_res, s_a, s_b;
  logic [5:0]   s_ctl;
  int           lat_c;
  assign s_done0 = use3 ? bus3.DONE0 : bus1.DONE0;
  assign s_done1 = use3 ? bus3.DONE1 : bus1.DONE1;
  assign s_res   = use3 ? bus3.RES : bus1.RES;
  assign s_cout  = use3 ? bus3.RES_COUT : bus1.RES_COUT;
  assign s_busy  = use3 ? bus3.BUSY : bus1.BUSY;
  assign s_a     = use3 ? bus3.ALU_A : bus1.ALU_A;
  assign s_b     = use3 ? bus3.ALU_B : bus1.ALU_B;
  assign s_ctl   = use3 ? {bus3.ALU_M, bus3.ALU_S, bus3.ALU_C0} : {bus1.ALU_M, bus1.ALU_S, bus1.ALU_C0};
  assign lat_c   = use3 ? 3 : 1;

  typedef struct {
    logic         port;
    logic [4:0]   op;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         cout;
    int           due;
  } exp_t;

  typedef struct {
    logic         port;
    logic [4:0]   op;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         cout;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic mon_en;
  int keep0, keep1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle monitor: pins, busy length, completions, requester drop after DONE
  initial begin
    exp_t e;
    int busy_run;
    busy_run = 0;
    forever begin
      @(negedge clk);
      check("done_excl", 64'(s_done0 & s_done1), 64'(0));
      if (mon_en) begin
        if (s_busy) begin
          busy_run++;
          if (sb_q.size() != 0) begin
            e = sb_q[0];
            check("pin_a", 64'(s_a), 64'(e.a));
            check("pin_b", 64'(s_b), 64'(e.b));
            check("pin_ctl", 64'(s_ctl), 64'({e.op, e.cin}));
          end else begin
            check("busy_no_op", 64'(s_busy), 64'(0));
          end
        end else begin
          check("idle_a", 64'(s_a), 64'(0));
          check("idle_b", 64'(s_b), 64'(0));
          check("idle_ctl", 64'(s_ctl), 64'(0));
          if (busy_run != 0) check("busy_len", 64'(busy_run), 64'(lat_c + 1));
          busy_run = 0;
        end
      end else begin
        busy_run = 0;
      end
      if (s_done0 || s_done1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'({s_done1, s_done0}), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("done_port", 64'(s_done1), 64'(e.port));
          check("done_cycle", 64'(cyc), 64'(e.due));
          check("res", 64'(s_res), 64'(e.res));
          check("res_cout", 64'(s_cout), 64'(e.cout));
        end
        if (s_done0) begin
          if (keep0 > 0) keep0--; else req0 = 1'b0;
        end
        if (s_done1) begin
          if (keep1 > 0) keep1--; else req1 = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic port, input logic [4:0] op, input logic cin,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    if (!port) begin
      op0 = op; cin0 = cin; a0 = a; b0 = b; req0 = 1'b1;
    end else begin
      op1 = op; cin1 = cin; a1 = a; b1 = b; req1 = 1'b1;
    end
  endtask

  // Expected completion computed by the bench ALU model
  task automatic push_model(input logic port, input logic [4:0] op, input logic cin,
                            input logic [N-1:0] a, input logic [N-1:0] b, input int due);
    exp_t e;
    logic [N:0] r;
    r = alu_model(a, b, op[4], op[3:0], cin);
    e = '{port, op, cin, a, b, r[N-1:0], r[N], due};
    sb_q.push_back(e);
  endtask

  // Wait for all expected completions, then one more cycle so the FSM is idle
  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
      req0 = 1'b0;
      req1 = 1'b0;
    end
    @(negedge clk);
  endtask

  // Both ports request together out of reset; port 0 re-requests once after its DONE
  task automatic tie_test();
    int t, l;
    l = lat_c;
    t = cyc + 1;
    keep0 = 1;
    drive(1'b0, 5'b0_1001, 1'b0, 32'd100, 32'd23);
    drive(1'b1, 5'b0_0110, 1'b1, 32'd7, 32'd2);
    push_model(1'b0, 5'b0_1001, 1'b0, 32'd100, 32'd23, t + l);
    push_model(1'b1, 5'b0_0110, 1'b1, 32'd7, 32'd2, t + l + (l + 2));
    push_model(1'b0, 5'b0_1001, 1'b0, 32'd100, 32'd23, t + l + 2 * (l + 2));
    drain(60);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    drive(v.port, v.op, v.cin, v.a, v.b);
    e = '{v.port, v.op, v.cin, v.a, v.b, v.res, v.cout, cyc + 1 + lat_c};
    sb_q.push_back(e);
    drain(40);
  endtask

  initial begin
    int t;
    vecs[0] = '{1'b0, 5'b0_1001, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
    vecs[1] = '{1'b1, 5'b0_1001, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1};
    vecs[2] = '{1'b0, 5'b0_0110, 1'b1, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b1};
    vecs[3] = '{1'b1, 5'b1_0110, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    vecs[4] = '{1'b0, 5'b1_1011, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 1'b0};
    vecs[5] = '{1'b1, 5'b1_1110, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};
    vecs[6] = '{1'b0, 5'b1_0000, 1'b0, 32'h0000_0000, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{1'b1, 5'b0_0110, 1'b0, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFD, 1'b0};

    rst = 1'b1; use3 = 1'b0; mon_en = 1'b1; keep0 = 0; keep1 = 0;
    req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0; cin0 = 1'b0; cin1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);

    // Reset values of both instances
    check("rst_busy1", 64'(bus1.BUSY), 64'(0));
    check("rst_done1", 64'({bus1.DONE1, bus1.DONE0}), 64'(0));
    check("rst_res1", 64'({bus1.RES_COUT, bus1.RES}), 64'(0));
    check("rst_pins1", 64'({bus1.ALU_M, bus1.ALU_S, bus1.ALU_C0, bus1.ALU_A}), 64'(0));
    check("rst_busy3", 64'(bus3.BUSY), 64'(0));
    check("rst_done3", 64'({bus3.DONE1, bus3.DONE0}), 64'(0));
    check("rst_res3", 64'({bus3.RES_COUT, bus3.RES}), 64'(0));
    check("rst_pins3", 64'({bus3.ALU_M, bus3.ALU_S, bus3.ALU_C0, bus3.ALU_B}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Each instance: first tie straight out of reset, then the vector table
    for (int d = 0; d < 2; d++) begin
      use3 = (d == 1);
      @(negedge clk);
      tie_test();
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    end

    // LAT=3: operand changes during HOLD are ignored
    use3 = 1'b1;
    t = cyc + 1;
    drive(1'b1, 5'b0_1001, 1'b1, 32'hDEAD_BEEF, 32'h0000_1111);
    push_model(1'b1, 5'b0_1001, 1'b1, 32'hDEAD_BEEF, 32'h0000_1111, t + 3);
    @(negedge clk);
    a0 = 32'h0000_1234; a1 = 32'h0000_0000; op1 = 5'b1_0000; b1 = 32'hFFFF_FFFF;
    drain(40);

    // LAT=3: reset in the second HOLD cycle aborts without DONE
    mon_en = 1'b0;
    drive(1'b0, 5'b0_1001, 1'b0, 32'h0000_0040, 32'h0000_0002);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", 64'(s_busy), 64'(1));
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    check("abort_busy_clr", 64'(s_busy), 64'(0));
    check("abort_done", 64'({s_done1, s_done0}), 64'(0));
    check("abort_res", 64'({s_cout, s_res}), 64'(0));
    check("abort_pins", 64'({s_ctl, s_a}), 64'(0));
    check("abort_pin_b", 64'(s_b), 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'({s_done1, s_done0}), 64'(0));
    end
    t = cyc + 1;
    drive(1'b0, 5'b0_0110, 1'b1, 32'h0000_0100, 32'h0000_0001);
    push_model(1'b0, 5'b0_0110, 1'b1, 32'h0000_0100, 32'h0000_0001, t + 3);
    drain(40);

    // LAT=3: port 0 requests back to back while port 1 asks once -> 0,1,0
    t = cyc + 1;
    keep0 = 1;
    drive(1'b0, 5'b1_1110, 1'b0, 32'h00FF_0000, 32'h0000_00FF);
    push_model(1'b0, 5'b1_1110, 1'b0, 32'h00FF_0000, 32'h0000_00FF, t + 3);
    @(negedge clk);
    drive(1'b1, 5'b0_1001, 1'b0, 32'h0000_0011, 32'h0000_0022);
    push_model(1'b1, 5'b0_1001, 1'b0, 32'h0000_0011, 32'h0000_0022, t + 3 + 5);
    push_model(1'b0, 5'b1_1110, 1'b0, 32'h00FF_0000, 32'h0000_00FF, t + 3 + 10);
    drain(60);

    // Both ports quiet: nothing moves on either instance
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", 64'({bus3.BUSY, bus1.BUSY}), 64'(0));
      check("idle_done", 64'({bus3.DONE1, bus3.DONE0, bus1.DONE1, bus1.DONE0}), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
